mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage pipeline, directly downstream of execute. Captures ALU result/store data/dest reg,
//  performs loads/stores over a req/gnt/rvalid data-memory port (byte enables, sign/zero extension), stalls
//  upstream while a memory access is outstanding, and delivers a registered writeback packet to the WB stage.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in REQ+WAIT before abort with bus_err_o; 0 disables the timeout
// PORTS
//  clk_i            in   1   clock
//  reset_ni         in   1   reset, asynchronous, active-low
//  valid_i          in   1   execute presents a valid instruction
//  alu_result_i     in   32  ALU result (memory address for loads/stores, writeback data otherwise)
//  read_data2_i     in   32  store data (rs2)
//  write_addr_reg_i in   5   destination register
//  funct3_i         in   3   instruction[14:12]: load/store size and sign
//  mem_read_i       in   1   load
//  mem_write_i      in   1   store
//  reg_write_i      in   1   instruction writes rd
//  stall_o          out  1   upstream holds its inputs; registered, equals (state != IDLE)
//  dmem_req_o       out  1   memory request
//  dmem_we_o        out  1   1 = write
//  dmem_addr_o      out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_be_o        out  4   byte enables
//  dmem_wdata_o     out  32  lane-aligned write data
//  dmem_gnt_i       in   1   request accepted
//  dmem_rvalid_i    in   1   response (load data valid, or store done)
//  dmem_rdata_i     in   32  load data word
//  wb_valid_o       out  1   writeback packet valid (1-cycle pulse per instruction)
//  wb_we_o          out  1   write rd (reg_write_i && rd!=0 && no error)
//  wb_addr_o        out  5   rd
//  wb_data_o        out  32  load result or ALU result
//  bus_err_o        out  1   1-cycle pulse with wb_valid_o on timeout
//  misalign_o       out  1   1-cycle pulse with wb_valid_o on misaligned access (only with macro)
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, all outputs 0. Asserting reset mid-access aborts it; dmem_req_o drops at once.
//  - FSM IDLE/REQ/WAIT. Inputs sampled only in IDLE with valid_i=1 (accept cycle T); ignored while stall_o=1.
//  - Non-memory op at T: wb_valid_o=1 at T+1, wb_data_o=alu_result_i, no stall.
//  - Load/store at T: capture all fields, IDLE->REQ. REQ: dmem_req_o=1, addr/we/be/wdata stable until dmem_gnt_i.
//    gnt -> WAIT (req drops next cycle). WAIT: dmem_rvalid_i -> IDLE, wb_valid_o=1 next cycle. rvalid earliest
//    cycle after gnt; minimum accept-to-wb_valid_o latency 3 cycles. Stores: wb_we_o=0.
//  - Store lanes: SB(000) be=4'b0001<<a[1:0], wdata={4{rs2[7:0]}}; SH(001) be=4'b0011<<{a[1],1'b0},
//    wdata={2{rs2[15:0]}}; SW(010) be=4'b1111. Other funct3 treated as word.
//  - Loads select lane by captured a[1:0]: LB/LBU(000/100) byte, LH/LHU(001/101) halfword at a[1]; 000/001
//    sign-extend, 100/101 zero-extend; LW(010) and others full word.
//  - Timeout: counter clears on accept, increments each REQ/WAIT cycle; at TIMEOUT_CYCLES without rvalid:
//    abort to IDLE, wb_valid_o=1, wb_we_o=0, wb_data_o=0, bus_err_o=1. rvalid/gnt arriving in IDLE ignored.
//  - gnt and rvalid in the same REQ cycle: gnt honoured, rvalid ignored (protocol violation, not supported).
//  - wb_* and error flags are registered; wb_valid_o=0 in every cycle without a completing instruction.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: at accept, halfword with a[0]!=0 or word with a[1:0]!=0 -> no memory
//    request, no stall, wb_valid_o=1, wb_we_o=0, misalign_o=1 at T+1.
//  Not defined: misalign_o tied 0; offending low address bits ignored (halfword a[0], word a[1:0] forced 0).
// TESTING
//  1 ADD result 0x1234, rd=5, reg_write -> T+1 wb_valid=1, wb_we=1, wb_addr=5, wb_data=0x1234, stall never 1.
//  2 LB a=0x103, mem word 0x80FF_0000, gnt immediate, rvalid next -> dmem_addr=0x100, wb_data=0xFFFF_FF80 at T+3;
//    LBU same -> 0x0000_0080.
//  3 SH a=0x102, rs2=0xABCD_1234 -> be=4'b1100, wdata=0x1234_1234, we=1; wb_we=0; stall_o high T+1..T+2.
//  4 LW, gnt delayed 3 cycles -> req/addr stable throughout; stall held; completes 3 cycles later than test 2.
//  5 LW, gnt then no rvalid, TIMEOUT_CYCLES=16 -> bus_err_o=1, wb_we=0; late rvalid afterwards ignored.
//  6 reset_ni low in WAIT -> dmem_req/stall/wb_valid 0 immediately; with MEM_MISALIGN_TRAP_EN, LW a=0x101 ->
//    no dmem_req, misalign_o=1 at T+1.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage: captures execute results, runs loads/stores over a req/gnt/rvalid
// data-memory port, stalls upstream while an access is outstanding, and emits a
// registered writeback packet. Optional feature macro: MEM_MISALIGN_TRAP_EN
// (misaligned halfword/word accesses trap at accept instead of being forced aligned).
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        valid_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] read_data2_i,
    input  logic [4:0]  write_addr_reg_i,
    input  logic [2:0]  funct3_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        reg_write_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        bus_err_o,
    output logic        misalign_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    // State and captured instruction
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic             r_we;
    logic [2:0]       r_funct3;
    logic [4:0]       r_rd;
    logic             r_reg_write;

    // Writeback registers
    logic             r_wb_valid;
    logic             r_wb_we;
    logic [4:0]       r_wb_addr;
    logic [31:0]      r_wb_data;
    logic             r_bus_err;
    logic             r_misalign;

    // Next-state values
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [31:0]      w_addr_nxt;
    logic [3:0]       w_be_nxt;
    logic [31:0]      w_wdata_nxt;
    logic             w_we_nxt;
    logic [2:0]       w_funct3_nxt;
    logic [4:0]       w_rd_nxt;
    logic             w_reg_write_nxt;
    logic             w_wb_valid_nxt;
    logic             w_wb_we_nxt;
    logic [4:0]       w_wb_addr_nxt;
    logic [31:0]      w_wb_data_nxt;
    logic             w_bus_err_nxt;
    logic             w_misalign_nxt;

    // Accept-side decode
    logic             w_is_mem;
    logic             w_sz_byte;
    logic             w_sz_half;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic             w_trap;
    logic             w_to_hit;

    // Load lane extraction
    logic [7:0]       w_ld_byte;
    logic [15:0]      w_ld_half;
    logic [31:0]      w_ld_data;

    assign w_is_mem = mem_read_i || mem_write_i;

    // Access size at accept; stores only honour 000/001 as narrow, loads also 100/101
    always_comb begin
        if (mem_write_i) begin
            w_sz_byte = (funct3_i == 3'b000);
            w_sz_half = (funct3_i == 3'b001);
        end else begin
            w_sz_byte = (funct3_i[1:0] == 2'b00);
            w_sz_half = (funct3_i[1:0] == 2'b01);
        end
    end

    // Byte enables and lane-replicated store data; halfword lane picked by a[1] only
    always_comb begin
        if (w_sz_byte) begin
            w_be    = 4'b0001 << alu_result_i[1:0];
            w_wdata = {4{read_data2_i[7:0]}};
        end else if (w_sz_half) begin
            w_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{read_data2_i[15:0]}};
        end else begin
            w_be    = 4'b1111;
            w_wdata = read_data2_i;
        end
        if (!mem_write_i) begin
            w_wdata = 32'h0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned halfword/word memory ops are trapped at accept
    always_comb begin
        w_trap = 1'b0;
        if (w_is_mem) begin
            if (w_sz_half) begin
                w_trap = alu_result_i[0];
            end else if (!w_sz_byte) begin
                w_trap = (alu_result_i[1:0] != 2'b00);
            end
        end
    end
`else
    assign w_trap = 1'b0;
`endif

    // Timeout fires on the last allowed REQ/WAIT cycle; 0 disables it
    assign w_to_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Select and extend the load lane from the captured address and funct3
    always_comb begin
        unique case (r_addr[1:0])
            2'd0:    w_ld_byte = dmem_rdata_i[7:0];
            2'd1:    w_ld_byte = dmem_rdata_i[15:8];
            2'd2:    w_ld_byte = dmem_rdata_i[23:16];
            default: w_ld_byte = dmem_rdata_i[31:24];
        endcase
        w_ld_half = r_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_data = {24'h0, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b101:  w_ld_data = {16'h0, w_ld_half};
            default: w_ld_data = dmem_rdata_i;
        endcase
    end

    // FSM next-state, capture and writeback packet formation
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_addr_nxt      = r_addr;
        w_be_nxt        = r_be;
        w_wdata_nxt     = r_wdata;
        w_we_nxt        = r_we;
        w_funct3_nxt    = r_funct3;
        w_rd_nxt        = r_rd;
        w_reg_write_nxt = r_reg_write;
        w_wb_valid_nxt  = 1'b0;
        w_wb_we_nxt     = 1'b0;
        w_wb_addr_nxt   = r_wb_addr;
        w_wb_data_nxt   = r_wb_data;
        w_bus_err_nxt   = 1'b0;
        w_misalign_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (valid_i) begin
                    if (!w_is_mem) begin
                        w_wb_valid_nxt = 1'b1;
                        w_wb_we_nxt    = reg_write_i && (write_addr_reg_i != 5'd0);
                        w_wb_addr_nxt  = write_addr_reg_i;
                        w_wb_data_nxt  = alu_result_i;
                    end else if (w_trap) begin
                        w_wb_valid_nxt = 1'b1;
                        w_wb_addr_nxt  = write_addr_reg_i;
                        w_wb_data_nxt  = 32'h0;
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = ST_REQ;
                        w_cnt_nxt       = '0;
                        w_addr_nxt      = alu_result_i;
                        w_be_nxt        = w_be;
                        w_wdata_nxt     = w_wdata;
                        w_we_nxt        = mem_write_i;
                        w_funct3_nxt    = funct3_i;
                        w_rd_nxt        = write_addr_reg_i;
                        w_reg_write_nxt = reg_write_i;
                    end
                end
            end
            ST_REQ: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_to_hit) begin
                    w_state_nxt    = ST_IDLE;
                    w_wb_valid_nxt = 1'b1;
                    w_wb_addr_nxt  = r_rd;
                    w_wb_data_nxt  = 32'h0;
                    w_bus_err_nxt  = 1'b1;
                end else if (dmem_gnt_i) begin
                    // rvalid in this same cycle is a protocol violation and ignored
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (dmem_rvalid_i) begin
                    w_state_nxt    = ST_IDLE;
                    w_wb_valid_nxt = 1'b1;
                    w_wb_we_nxt    = !r_we && r_reg_write && (r_rd != 5'd0);
                    w_wb_addr_nxt  = r_rd;
                    w_wb_data_nxt  = r_we ? r_addr : w_ld_data;
                end else if (w_to_hit) begin
                    w_state_nxt    = ST_IDLE;
                    w_wb_valid_nxt = 1'b1;
                    w_wb_addr_nxt  = r_rd;
                    w_wb_data_nxt  = 32'h0;
                    w_bus_err_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, capture and writeback registers; reset aborts any access in flight
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= 32'h0;
            r_be        <= 4'h0;
            r_wdata     <= 32'h0;
            r_we        <= 1'b0;
            r_funct3    <= 3'h0;
            r_rd        <= 5'h0;
            r_reg_write <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_we     <= 1'b0;
            r_wb_addr   <= 5'h0;
            r_wb_data   <= 32'h0;
            r_bus_err   <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_be        <= w_be_nxt;
            r_wdata     <= w_wdata_nxt;
            r_we        <= w_we_nxt;
            r_funct3    <= w_funct3_nxt;
            r_rd        <= w_rd_nxt;
            r_reg_write <= w_reg_write_nxt;
            r_wb_valid  <= w_wb_valid_nxt;
            r_wb_we     <= w_wb_we_nxt;
            r_wb_addr   <= w_wb_addr_nxt;
            r_wb_data   <= w_wb_data_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_misalign  <= w_misalign_nxt;
        end
    end

    // Memory port is driven only while requesting; all fields held stable in REQ
    always_comb begin
        stall_o      = (r_state != ST_IDLE);
        dmem_req_o   = (r_state == ST_REQ);
        dmem_we_o    = dmem_req_o && r_we;
        dmem_addr_o  = dmem_req_o ? {r_addr[31:2], 2'b00} : 32'h0;
        dmem_be_o    = dmem_req_o ? r_be : 4'h0;
        dmem_wdata_o = dmem_req_o ? r_wdata : 32'h0;
        wb_valid_o   = r_wb_valid;
        wb_we_o      = r_wb_we;
        wb_addr_o    = r_wb_addr;
        wb_data_o    = r_wb_data;
        bus_err_o    = r_bus_err;
        misalign_o   = r_misalign;
    end

endmodule
